// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet burst generator: emits num_pkts packets of pkt_len beats
// with an incrementing data pattern starting at seed, optional inter-packet gap.
module axis_pkt_gen #(
  parameter int unsigned DW      = 8,
  parameter int unsigned LW      = 12,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] pkt_len,
  input  logic [7:0]    num_pkts,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic [7:0]    pkt_cnt,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready
);

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [7:0]    num_q;
  logic [LW-1:0] idx;
  logic [GW-1:0] gap_cnt;

  logic          hs;
  logic [LW-1:0] idx_nx;
  logic [LW-1:0] len_m1;
  logic [7:0]    cnt_nx;

  // Handshake and next-value helpers for the sequencer
  assign hs     = m_tvalid & m_tready;
  assign idx_nx = idx + LW'(1);
  assign len_m1 = len_q - LW'(1);
  assign cnt_nx = pkt_cnt + 8'd1;

  // Burst sequencer: state, beat index, gap counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      num_q    <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pkt_cnt <= '0;
            if ((pkt_len != '0) && (num_pkts != '0)) begin
              len_q    <= pkt_len;
              num_q    <= num_pkts;
              idx      <= '0;
              gap_cnt  <= '0;
              m_tdata  <= seed;
              m_tvalid <= 1'b1;
              m_tlast  <= (pkt_len == LW'(1));
              busy     <= 1'b1;
              state    <= SEND;
            end else begin
              // Empty command completes immediately without touching the stream
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        SEND: begin
          if (hs) begin
            m_tdata <= m_tdata + DW'(1);
            if (m_tlast) begin
              pkt_cnt <= cnt_nx;
              idx     <= '0;
              if (cnt_nx == num_q) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= FIN;
              end else if (GAP_CYC == 0) begin
                m_tlast <= (len_q == LW'(1));
              end else begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                gap_cnt  <= '0;
                state    <= GAP;
              end
            end else begin
              idx     <= idx_nx;
              m_tlast <= (idx_nx == len_m1);
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            m_tvalid <= 1'b1;
            m_tlast  <= (len_q == LW'(1));
            state    <= SEND;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: two instances (GAP_CYC=2 and GAP_CYC=0)
// share stimulus; a behavioural model queues expected beats and completions.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] pkt_len = '0;
  logic [7:0]  num_pkts = '0;
  logic [7:0]  seed = '0;
  logic        m_tready = 1'b1;

  logic       g_busy, g_done, g_tvalid, g_tlast;
  logic [7:0] g_pkt_cnt, g_tdata;
  logic       z_busy, z_done, z_tvalid, z_tlast;
  logic [7:0] z_pkt_cnt, z_tdata;

  always #5 clk = ~clk;

  axis_pkt_gen #(.DW(8), .LW(12), .GAP_CYC(2)) dut_g (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .seed(seed), .busy(g_busy), .done(g_done), .pkt_cnt(g_pkt_cnt),
    .m_tdata(g_tdata), .m_tvalid(g_tvalid), .m_tlast(g_tlast), .m_tready(m_tready)
  );

  axis_pkt_gen #(.DW(8), .LW(12), .GAP_CYC(0)) dut_z (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .seed(seed), .busy(z_busy), .done(z_done), .pkt_cnt(z_pkt_cnt),
    .m_tdata(z_tdata), .m_tvalid(z_tvalid), .m_tlast(z_tlast), .m_tready(m_tready)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       pkt_first;
    logic       burst_first;
  } beat_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       degen;
  } done_t;

  beat_t exp_q[2][$];
  done_t done_q[2][$];

  int cyc = 0;
  int cmd_cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_dones = 0;
  int done_seen[2] = '{0, 0};
  bit bp = 1'b0;

  logic       prev_v[2]  = '{1'b0, 1'b0};
  logic       prev_hs[2] = '{1'b0, 1'b0};
  logic       prev_l[2]  = '{1'b0, 1'b0};
  logic [7:0] prev_d[2]  = '{8'h0, 8'h0};
  int onset[2]   = '{0, 0};
  int last_tl[2] = '{0, 0};
  int last_hs[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit=%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, u, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and done pulse
  task automatic mon_step(input int u);
    logic       v, l, b, d, hs;
    logic [7:0] dt, pc;
    beat_t      e;
    done_t      de;
    v  = (u == 0) ? g_tvalid  : z_tvalid;
    l  = (u == 0) ? g_tlast   : z_tlast;
    b  = (u == 0) ? g_busy    : z_busy;
    d  = (u == 0) ? g_done    : z_done;
    dt = (u == 0) ? g_tdata   : z_tdata;
    pc = (u == 0) ? g_pkt_cnt : z_pkt_cnt;
    if (rst) begin
      prev_v[u]  = 1'b0;
      prev_hs[u] = 1'b0;
      return;
    end
    hs = v & m_tready;
    if (prev_v[u] && !prev_hs[u]) begin
      chk("stall_valid_held", u, 32'(v), 32'd1);
      chk("stall_data_held", u, 32'(dt), 32'(prev_d[u]));
      chk("stall_last_held", u, 32'(l), 32'(prev_l[u]));
    end
    if (v) chk("busy_while_valid", u, 32'(b), 32'd1);
    if (v && (!prev_v[u] || prev_hs[u])) onset[u] = cyc;
    if (hs) begin
      chk("beat_expected", u, 32'(exp_q[u].size() > 0), 32'd1);
      if (exp_q[u].size() > 0) begin
        e = exp_q[u].pop_front();
        chk("beat_data", u, 32'(dt), 32'(e.data));
        chk("beat_last", u, 32'(l), 32'(e.last));
        if (e.burst_first)
          chk("start_latency", u, 32'(onset[u] - cmd_cyc), 32'd1);
        else if (e.pkt_first)
          chk("pkt_gap", u, 32'(onset[u] - last_tl[u]), 32'(gap_of(u) + 1));
      end
      if (l) last_tl[u] = cyc;
      last_hs[u] = cyc;
    end
    if (d) begin
      done_seen[u]++;
      chk("done_expected", u, 32'(done_q[u].size() > 0), 32'd1);
      if (done_q[u].size() > 0) begin
        de = done_q[u].pop_front();
        chk("done_pkt_cnt", u, 32'(pc), 32'(de.cnt));
        chk("done_busy_low", u, 32'(b), 32'd0);
        chk("done_valid_low", u, 32'(v), 32'd0);
        chk("done_timing", u, 32'(cyc), 32'((de.degen ? cmd_cyc : last_hs[u]) + 1));
      end
    end
    prev_v[u]  = v;
    prev_hs[u] = hs;
    prev_l[u]  = l;
    prev_d[u]  = dt;
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon_step(u);
  end

  // Downstream ready: held high, or randomly toggled when backpressure is on
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expand a command into its expected beat list
  task automatic issue(input logic [7:0] s, input logic [11:0] l, input logic [7:0] n);
    logic [7:0] dv;
    for (int u = 0; u < 2; u++) begin
      if (l == 0 || n == 0) begin
        done_q[u].push_back('{cnt: 8'd0, degen: 1'b1});
      end else begin
        dv = s;
        for (int p = 0; p < int'(n); p++) begin
          for (int k = 0; k < int'(l); k++) begin
            exp_q[u].push_back('{data: dv, last: (k == int'(l) - 1),
                                 pkt_first: (k == 0), burst_first: (p == 0 && k == 0)});
            dv = dv + 8'd1;
          end
        end
        done_q[u].push_back('{cnt: n, degen: 1'b0});
      end
    end
    exp_dones++;
    seed     = s;
    pkt_len  = l;
    num_pkts = n;
    start    = 1'b1;
    cmd_cyc  = cyc;
    cyc_step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((done_seen[0] != exp_dones || done_seen[1] != exp_dones) && t < 3000) begin
      cyc_step();
      t++;
    end
    chk("burst_completes", -1, 32'(t < 3000), 32'd1);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_tvalid"}, 0, 32'(g_tvalid), 32'd0);
    chk({name, "_tlast"},  0, 32'(g_tlast),  32'd0);
    chk({name, "_tdata"},  0, 32'(g_tdata),  32'd0);
    chk({name, "_busy"},   0, 32'(g_busy),   32'd0);
    chk({name, "_done"},   0, 32'(g_done),   32'd0);
    chk({name, "_pkt_cnt"},0, 32'(g_pkt_cnt),32'd0);
    chk({name, "_tvalid"}, 1, 32'(z_tvalid), 32'd0);
    chk({name, "_tlast"},  1, 32'(z_tlast),  32'd0);
    chk({name, "_tdata"},  1, 32'(z_tdata),  32'd0);
    chk({name, "_busy"},   1, 32'(z_busy),   32'd0);
    chk({name, "_done"},   1, 32'(z_done),   32'd0);
    chk({name, "_pkt_cnt"},1, 32'(z_pkt_cnt),32'd0);
  endtask

  initial begin
    logic [7:0]  rs, rn;
    logic [11:0] rl;

    // Reset state
    rst = 1'b1;
    cyc_step();
    cyc_step();
    chk_quiet("reset");
    rst = 1'b0;
    cyc_step();

    // Basic burst, full-rate ready
    bp = 1'b0;
    issue(8'h10, 12'd4, 8'd2);
    wait_done();
    repeat (3) cyc_step();
    chk("pkt_cnt_hold", 0, 32'(g_pkt_cnt), 32'd2);
    chk("pkt_cnt_hold", 1, 32'(z_pkt_cnt), 32'd2);

    // Backpressure plus a start pulse while busy that must be ignored
    bp = 1'b1;
    issue(8'h10, 12'd4, 8'd2);
    repeat (3) cyc_step();
    seed     = 8'h99;
    pkt_len  = 12'd2;
    num_pkts = 8'd1;
    start    = 1'b1;
    cyc_step();
    start = 1'b0;
    wait_done();
    bp = 1'b0;
    repeat (4) cyc_step();

    // Data wrap with single-beat packets
    issue(8'hFE, 12'd1, 8'd4);
    wait_done();
    chk("wrap_pkt_cnt", 0, 32'(g_pkt_cnt), 32'd4);
    chk("wrap_pkt_cnt", 1, 32'(z_pkt_cnt), 32'd4);

    // Degenerate commands
    issue(8'h55, 12'd0, 8'd3);
    wait_done();
    issue(8'h55, 12'd5, 8'd0);
    wait_done();

    // Reset during the third beat of a 4-beat packet
    issue(8'h20, 12'd4, 8'd1);
    cyc_step();
    cyc_step();
    rst = 1'b1;
    cyc_step();
    chk_quiet("midreset");
    for (int u = 0; u < 2; u++) begin
      exp_q[u].delete();
      done_q[u].delete();
    end
    exp_dones = done_seen[0];
    rst = 1'b0;
    cyc_step();
    issue(8'h00, 12'd3, 8'd1);
    wait_done();

    // Randomized commands and backpressure
    for (int i = 0; i < 20; i++) begin
      bp = ($urandom_range(0, 1) == 1);
      cyc_step();
      rs = 8'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 9));
      rn = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      issue(rs, rl, rn);
      wait_done();
    end
    bp = 1'b0;
    repeat (5) cyc_step();

    for (int u = 0; u < 2; u++) begin
      chk("beats_left", u, 32'(exp_q[u].size()), 32'd0);
      chk("dones_left", u, 32'(done_q[u].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream packet transmitter that drives the upstream (slave) side of the team's store-and-forward AXI-Stream FIFO. On a start command it emits a burst of `num_pkts` packets of `pkt_len` beats each, with an incrementing data pattern seeded by `seed`. `m_tlast` is asserted on the final beat of every packet, and `m_tready` backpressure is honoured. It serves as the traffic source for FIFO bring-up and loopback tests. Completion is reported by a `done` pulse and a packet counter.

## Interface
- `DW`, 8: data width of `m_tdata` and `seed`.
- `LW`, 12: width of `pkt_len`. The maximum packet is 2^LW-1 beats.
- `GAP_CYC`, 2: idle cycles inserted between consecutive packets. 0 means back-to-back.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  launch command. Sampled only in IDLE.
- `pkt_len`  in  LW  beats per packet. Latched on an accepted `start`.
- `num_pkts`  in  8  packets per burst. Latched on an accepted `start`.
- `seed`  in  DW  data value of the first beat of the burst. Latched on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the cycle of the final handshake.
- `done`  out  1  one-cycle pulse when the burst has completed.
- `pkt_cnt`  out  8  packets fully sent in the current or most recent burst.
- `m_tdata`  out  DW  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tlast`  out  1  final beat of a packet.
- `m_tready`  in  1  downstream ready.

## Operation
- States:
  - IDLE: outputs quiet.
  - SEND: beats are presented on the stream.
  - GAP: counts GAP_CYC idle cycles.
  - FIN: asserts `done` for one cycle, then returns to IDLE.
- IDLE, `start`=1, `pkt_len`≠0 and `num_pkts`≠0:
  - latch the three inputs; clear `pkt_cnt`, the beat index and the gap counter;
  - load the data register with `seed`;
  - go to SEND.
- IDLE, `start`=1 with `pkt_len`=0 or `num_pkts`=0: go to FIN. No beats are emitted and `pkt_cnt` becomes 0.
- `start` in any state other than IDLE is ignored. Inputs are not re-sampled during a burst.
- A handshake is a cycle with `m_tvalid` & `m_tready`.
- On each handshake in SEND:
  - the data register increments modulo 2^DW;
  - the beat index increments.
- The data pattern continues across packet boundaries: the first beat of packet k+1 is the last beat of packet k, plus 1.
- `m_tlast`=1 exactly when the beat index equals latched `pkt_len`-1. A `pkt_len` of 1 gives `m_tlast` on every beat.
- On the handshake of a `m_tlast` beat:
  - `pkt_cnt` increments and the beat index clears;
  - if the new `pkt_cnt` equals `num_pkts`, go to FIN;
  - else, if GAP_CYC=0, stay in SEND;
  - else, go to GAP.
- GAP: `m_tvalid`=0 for exactly GAP_CYC cycles, then return to SEND.
- The index is compared with a LW-bit equality. No wrap is possible within a packet because `pkt_len` ≤ 2^LW-1.
- `pkt_cnt` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset: on the first edge with `rst`=1, all of the following are forced to 0:
  - `m_tvalid`, `m_tlast`, `m_tdata`;
  - `busy`, `done`, `pkt_cnt`;
  - the state register is forced to IDLE.
- Reset mid-packet: `m_tvalid` drops on that edge. The partial packet is abandoned with no `m_tlast` and no `done`.
- All outputs are registered. There is no combinational path from `m_tready` to any output.
- Latency from `start`:
  - `start` sampled at edge T: `m_tvalid`=1 and `busy`=1 after edge T, i.e. in cycle T+1.
  - The first beat carries `seed`.
- AXIS rule: once `m_tvalid`=1, `m_tdata` and `m_tlast` are held stable until a handshake. `m_tvalid` never drops without a handshake, except on reset.
- With `m_tready` held at 1, one beat transfers per cycle, so a packet takes exactly `pkt_len` cycles.
- Packet spacing: the gap from the `m_tlast` handshake to the next first-beat `m_tvalid` is GAP_CYC idle cycles.
- Completion, final handshake at edge F:
  - `busy`=0 and `m_tvalid`=0 from cycle F+1;
  - `done`=1 in cycle F+1 only;
  - a new `start` is accepted from cycle F+2.
- A zero-length command sampled at edge T gives `done`=1 in cycle T+1, with `busy` remaining 0.

## Test plan
- Basic burst:
  - stimulus: DW=8, GAP_CYC=2, `m_tready`=1; `start` with `seed`=0x10, `pkt_len`=4, `num_pkts`=2;
  - required response: beats 0x10–0x13 with `m_tlast` on 0x13, then 2 idle cycles, then 0x14–0x17 with `m_tlast` on 0x17;
  - `done` one cycle after 0x17; `pkt_cnt`=2.
- Backpressure:
  - stimulus: same command, with `m_tready` toggled 1,0,0,1,… randomly;
  - required response: `m_tdata`/`m_tlast` stable while stalled; the same 8-beat sequence with no loss or duplication.
- Wrap and back-to-back:
  - stimulus: GAP_CYC=0; `seed`=0xFE, `pkt_len`=1, `num_pkts`=4;
  - required response: 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles, each with `m_tlast`=1; `pkt_cnt`=4.
- Degenerate command:
  - stimulus: `pkt_len`=0, `num_pkts`=3;
  - required response: no `m_tvalid`; `done` in cycle T+1; `pkt_cnt`=0.
  - stimulus: `start` pulsed while `busy`;
  - required response: the pulse is ignored, shown by an unchanged sequence and count.
- Reset mid-packet:
  - stimulus: `rst` asserted on beat 2 of a 4-beat packet;
  - required response: all outputs 0 on the next edge.
  - stimulus: a subsequent `start` with `seed`=0x00, `pkt_len`=3, `num_pkts`=1;
  - required response: clean beats 0x00–0x02 with `m_tlast` on 0x02.
- Loopback: connect to the FIFO upstream port and check that the packet data and `m_tlast` position are reproduced at the FIFO output.
